// File: rtl/otter_lsu.sv
// Load/store initiator for the OTTER BRAM data port: one request at a time,
// registered memory strobes held for a single access cycle, faulting bad requests early.
module otter_lsu #(
  parameter logic [31:0] MEM_BYTES = 32'h0000_4000,
  parameter logic [31:0] IO_BASE   = 32'h0001_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_sign_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_fault_o,
  output logic        resp_io_o,
  output logic        mem_rden2_o,
  output logic        mem_we2_o,
  output logic [31:0] mem_addr2_o,
  output logic [31:0] mem_din2_o,
  output logic [1:0]  mem_size_o,
  output logic        mem_sign_o,
  input  logic [31:0] mem_dout2_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic        we_q, we_d;
  logic        rden_q, rden_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        io_q, io_d;

  logic accept;
  logic misaligned;
  logic unmapped;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      rden_q  <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      io_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      we_q    <= we_d;
      rden_q  <= rden_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      io_q    <= io_d;
    end
  end

  always_comb begin
    misaligned = (req_size_i == 2'd3) ||
                 (req_size_i == 2'd1 && req_addr_i[0]) ||
                 (req_size_i == 2'd2 && req_addr_i[1:0] != 2'b00);
    unmapped   = (req_addr_i >= MEM_BYTES) && (req_addr_i < IO_BASE);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    size_d  = size_q;
    sign_d  = sign_q;
    we_d    = we_q;
    rden_d  = rden_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    io_d    = io_q;

    req_ready_o = (state_q == IDLE) || (state_q == RESP && resp_ready_i);
    accept      = req_valid_i && req_ready_o;

    case (state_q)
      ACCESS: begin
        rdata_d = we_q ? 32'h0 : mem_dout2_i;
        we_d    = 1'b0;
        rden_d  = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new request may be taken in the same edge that retires a response.
    if (accept) begin
      rdata_d = 32'h0;
      if (misaligned || unmapped) begin
        state_d = RESP;
        fault_d = 1'b1;
        io_d    = 1'b0;
        we_d    = 1'b0;
        rden_d  = 1'b0;
      end else begin
        state_d = ACCESS;
        fault_d = 1'b0;
        io_d    = (req_addr_i >= IO_BASE);
        addr_d  = req_addr_i;
        din_d   = req_wdata_i;
        size_d  = req_size_i;
        sign_d  = req_sign_i;
        we_d    = req_we_i;
        rden_d  = ~req_we_i;
      end
    end
  end

  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_fault_o = fault_q;
  assign resp_io_o    = io_q;
  assign mem_rden2_o  = rden_q;
  assign mem_we2_o    = we_q;
  assign mem_addr2_o  = addr_q;
  assign mem_din2_o   = din_q;
  assign mem_size_o   = size_q;
  assign mem_sign_o   = sign_q;

endmodule

// File: tb/tb_otter_lsu.sv
// Directed bench for otter_lsu with a negedge-sampling BRAM/MMIO model.
module tb_otter_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_sign;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_fault, resp_io;
  logic [31:0] resp_rdata;
  logic        mem_rden2, mem_we2, mem_sign;
  logic [31:0] mem_addr2, mem_din2, mem_dout;
  logic [1:0]  mem_size;

  int nchk = 0;
  int nerr = 0;

  otter_lsu dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_sign_i(req_sign),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_fault_o(resp_fault), .resp_io_o(resp_io),
    .mem_rden2_o(mem_rden2), .mem_we2_o(mem_we2), .mem_addr2_o(mem_addr2),
    .mem_din2_o(mem_din2), .mem_size_o(mem_size), .mem_sign_o(mem_sign),
    .mem_dout2_i(mem_dout)
  );

  always #5 clk = ~clk;

  // Memory model: 16 KB RAM, MMIO at/above 0x1_0000 reads back 0x55.
  logic [31:0] mem [0:4095];

  function automatic logic [31:0] mread(input logic [31:0] a, input logic [1:0] s,
                                        input logic u);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    if (a >= 32'h0001_0000) return 32'h55;
    w = mem[a[13:2]];
    b = w[8*a[1:0] +: 8];
    h = w[16*a[1] +: 16];
    case (s)
      2'd0:    return u ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    return u ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      mem[4] = 32'hDEAD_BEEF;
      mem_dout = 32'h0;
    end else begin
      if (mem_rden2) mem_dout = mread(mem_addr2, mem_size, mem_sign);
      if (mem_we2 && mem_addr2 < 32'h0001_0000) begin
        case (mem_size)
          2'd0:    mem[mem_addr2[13:2]][8*mem_addr2[1:0] +: 8] = mem_din2[7:0];
          2'd1:    mem[mem_addr2[13:2]][16*mem_addr2[1] +: 16] = mem_din2[15:0];
          default: mem[mem_addr2[13:2]] = mem_din2;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] rdata;
    logic        fault;
    logic        io;
  } vec_t;

  vec_t vecs [19];

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic u);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    req_size = s; req_sign = u;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int lat, wc, rc;
    logic [1:0]  sz;
    logic [31:0] ad;
    lat = 0; wc = 0; rc = 0; sz = 2'd0; ad = 32'h0;
    chk($sformatf("v%0d req_ready", n), {31'h0, req_ready}, 32'h1);
    drive(v.we, v.addr, v.wdata, v.size, v.sign);
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!resp_valid && lat < 8) begin
      if (mem_we2) wc++;
      if (mem_rden2) rc++;
      if (mem_we2 || mem_rden2) begin sz = mem_size; ad = mem_addr2; end
      @(posedge clk); #1;
      lat++;
    end
    if (mem_we2) wc++;
    if (mem_rden2) rc++;
    chk($sformatf("v%0d latency", n), lat, v.fault ? 32'd0 : 32'd1);
    chk($sformatf("v%0d resp_valid", n), {31'h0, resp_valid}, 32'h1);
    chk($sformatf("v%0d rdata", n), resp_rdata, v.rdata);
    chk($sformatf("v%0d fault", n), {31'h0, resp_fault}, {31'h0, v.fault});
    chk($sformatf("v%0d io", n), {31'h0, resp_io}, {31'h0, v.io});
    chk($sformatf("v%0d we2 cycles", n), wc, (!v.fault && v.we) ? 32'd1 : 32'd0);
    chk($sformatf("v%0d rden2 cycles", n), rc, (!v.fault && !v.we) ? 32'd1 : 32'd0);
    if (!v.fault) begin
      chk($sformatf("v%0d mem_size", n), {30'h0, sz}, {30'h0, v.size});
      chk($sformatf("v%0d mem_addr", n), ad, v.addr);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    //            we    addr          wdata         sz    sign  rdata         flt   io
    vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,        2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'h80FF_FF7F, 2'd2, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,        2'd0, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0012, 32'h0,        2'd1, 1'b1, 32'h0000_80FF, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0012, 32'h0,        2'd1, 1'b0, 32'hFFFF_80FF, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,        2'd0, 1'b1, 32'h0000_007F, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0002, 32'h0000_1234, 2'd1, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,        2'd2, 1'b0, 32'h1234_0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0006, 32'h0,        2'd2, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0003, 32'h0,        2'd1, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0020, 32'h0,        2'd3, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_8000, 32'h0,        2'd2, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[12] = '{1'b1, 32'hFFFF_FFFF, 32'h1,        2'd2, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[13] = '{1'b1, 32'h1100_0000, 32'h0000_00A5, 2'd2, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[14] = '{1'b0, 32'h1100_0000, 32'h0,        2'd2, 1'b0, 32'h0000_0055, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 32'h0001_0000, 32'h0,        2'd2, 1'b0, 32'h0000_0055, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 32'h0000_3FFF, 32'h0000_00AB, 2'd0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[17] = '{1'b0, 32'h0000_3FFF, 32'h0,        2'd0, 1'b1, 32'h0000_00AB, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 32'h0000_4000, 32'h0,        2'd2, 1'b0, 32'h0,        1'b1, 1'b0};

    rst = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_sign = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst strobes", {30'h0, mem_we2, mem_rden2}, 32'h0);
    chk("rst mem_addr", mem_addr2, 32'h0);
    chk("rst mem_din", mem_din2, 32'h0);
    chk("rst size/sign", {29'h0, mem_size, mem_sign}, 32'h0);
    chk("rst rdata", resp_rdata, 32'h0);
    chk("rst fault/io", {30'h0, resp_fault, resp_io}, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);

    // Back-to-back: new requests accepted on the edge that retires a response.
    drive(1'b0, 32'h0000_0010, 32'h0, 2'd2, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b first valid", {31'h0, resp_valid}, 32'h1);
    chk("b2b first rdata", resp_rdata, 32'h80FF_FF7F);
    drive(1'b0, 32'h0000_0000, 32'h0, 2'd2, 1'b0);
    chk("b2b req_ready in RESP", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    drive(1'b0, 32'h0000_0006, 32'h0, 2'd2, 1'b0);
    chk("b2b access valid", {31'h0, resp_valid}, 32'h0);
    chk("b2b access rden", {31'h0, mem_rden2}, 32'h1);
    chk("b2b access ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    chk("b2b second rdata", resp_rdata, 32'h1234_0000);
    chk("b2b second valid", {31'h0, resp_valid}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b fault valid", {31'h0, resp_valid}, 32'h1);
    chk("b2b fault flag", {31'h0, resp_fault}, 32'h1);
    chk("b2b fault rdata", resp_rdata, 32'h0);
    chk("b2b fault rden", {31'h0, mem_rden2}, 32'h0);
    @(posedge clk); #1;
    chk("b2b idle", {31'h0, resp_valid}, 32'h0);

    // Back-pressure: response held while a pending request waits.
    resp_ready = 1'b0;
    drive(1'b0, 32'h0000_3FFC, 32'h0, 2'd2, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0000_0010, 32'h0, 2'd2, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d valid", i), {31'h0, resp_valid}, 32'h1);
      chk($sformatf("hold%0d rdata", i), resp_rdata, 32'hAB00_0000);
      chk($sformatf("hold%0d req_ready", i), {31'h0, req_ready}, 32'h0);
      chk($sformatf("hold%0d strobes", i), {30'h0, mem_we2, mem_rden2}, 32'h0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    #1;
    chk("hold release ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("hold next access", {30'h0, resp_valid, mem_rden2}, 32'h1);
    @(posedge clk); #1;
    chk("hold next rdata", resp_rdata, 32'h80FF_FF7F);
    @(posedge clk); #1;

    // Reset during the access cycle of a store.
    drive(1'b1, 32'h0000_0020, 32'h1111_2222, 2'd2, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst-mid we2 before", {31'h0, mem_we2}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst-mid we2 async", {31'h0, mem_we2}, 32'h0);
    chk("rst-mid resp_valid", {31'h0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst-mid idle ready", {31'h0, req_ready}, 32'h1);
    chk("rst-mid mem_addr", mem_addr2, 32'h0);
    @(posedge clk); #1;
    chk("rst-mid stays idle", {31'h0, resp_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
